// File: rtl/ysyx_25070198_csr_exec.sv
// Zicsr executor: reads the addressed CSR, then optionally writes RW/RS/RC of the operand back.
// Latency: accept->out_valid is 3 cycles with a write, 2 without, 1 for a bad funct3.
// Backpressure: one op in flight; in_ready only in IDLE, result held in RESP until out_ready.
module ysyx_25070198_csr_exec #(
    parameter bit RO_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [11:0] in_addr,
    input  logic [31:0] in_rs1,
    input  logic [4:0]  in_uimm,
    output logic        csr_wen,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  op_q;        // funct3[1:0]: 01 RW, 10 RS, 11 RC
    logic [31:0] opnd_q;      // rs1 value or zero-extended zimm
    logic        do_write_q;
    logic [31:0] new_val;
    logic        ro_hit;

    // csr_addr doubles as the latched address, so the read-only test looks at it directly
    assign ro_hit = RO_CHECK && (csr_addr[11:10] == 2'b11);

    // Write-back value built from the value being sampled in READ, never a later re-read
    always_comb begin
        new_val = opnd_q;
        case (op_q)
            2'b01:   new_val = opnd_q;
            2'b10:   new_val = csr_rdata | opnd_q;
            2'b11:   new_val = csr_rdata & ~opnd_q;
            default: new_val = opnd_q;
        endcase
    end

    // Single FSM; every output is a register so nothing downstream sees combinational paths
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            csr_wen     <= 1'b0;
            csr_addr    <= 12'h000;
            csr_wdata   <= 32'h0;
            out_valid   <= 1'b0;
            out_rdata   <= 32'h0;
            out_illegal <= 1'b0;
            op_q        <= 2'b00;
            opnd_q      <= 32'h0;
            do_write_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        csr_addr   <= in_addr;
                        op_q       <= in_funct3[1:0];
                        opnd_q     <= in_funct3[2] ? {27'b0, in_uimm} : in_rs1;
                        // RW always writes; set/clear only when the rs1 field is non-zero
                        do_write_q <= (in_funct3[1:0] == 2'b01) || (in_uimm != 5'd0);
                        if (in_funct3[1:0] == 2'b00) begin
                            out_illegal <= 1'b1;
                            out_rdata   <= 32'h0;
                            out_valid   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    out_rdata <= csr_rdata;
                    if (do_write_q && ro_hit) begin
                        out_illegal <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (do_write_q) begin
                        csr_wen   <= 1'b1;
                        csr_wdata <= new_val;
                        state     <= WRITE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    csr_wen   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_illegal <= 1'b0;
                        in_ready    <= 1'b1;
                        csr_addr    <= 12'h000;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25070198_csr_exec.sv
// Bench for the Zicsr executor with a small CSR file model attached.
// Latency: checked per op against the expected handshake cycle counts.
// Backpressure: holds out_ready low on some ops and checks the result stays put.
module tb_ysyx_25070198_csr_exec;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [11:0] in_addr;
    logic [31:0] in_rs1;
    logic [4:0]  in_uimm;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    ysyx_25070198_csr_exec #(.RO_CHECK(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_rs1     (in_rs1),
        .in_uimm    (in_uimm),
        .csr_wen    (csr_wen),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_illegal(out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CSR file model: mcycle free-runs, mcycleh/mscratch are plain registers
    logic        mdl_init;
    logic [31:0] mcycle, mcycleh, mscratch;

    always @(posedge clock) begin
        if (mdl_init) begin
            mcycle   <= 32'h0;
            mcycleh  <= 32'h7;
            mscratch <= 32'hF0;
        end else begin
            mcycle <= (csr_wen && csr_addr == 12'hB00) ? csr_wdata : mcycle + 32'd1;
            if (csr_wen && csr_addr == 12'hB80) mcycleh  <= csr_wdata;
            if (csr_wen && csr_addr == 12'h340) mscratch <= csr_wdata;
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'hF11: csr_rdata = 32'h79737978;
            12'hF12: csr_rdata = 32'h017E8A76;
            12'hB00: csr_rdata = mcycle;
            12'hB80: csr_rdata = mcycleh;
            12'h340: csr_rdata = mscratch;
            default: csr_rdata = 32'h0;
        endcase
    end

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic [31:0] rdata;
        logic        illegal;
        logic        wen;
        logic [31:0] wdata;
        int          lat;
        int          hold;
        bit          use_mcycle;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    exp_t sbq[$];
    vec_t vec[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          wen_n;
        int          wen_lat;
        logic [31:0] wd;
        logic [11:0] wa;
        bit          seen;
        wd = 32'h0; wa = 12'h0; wen_lat = 0;
        @(negedge clock);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_funct3 = v.funct3;
        in_addr   = v.addr;
        in_rs1    = v.rs1;
        in_uimm   = v.uimm;
        e.rdata   = v.use_mcycle ? mcycle + 32'd1 : v.rdata;
        e.illegal = v.illegal;
        sbq.push_back(e);
        @(negedge clock);
        // keep presenting junk while busy; the block must ignore it
        in_funct3 = 3'($urandom);
        in_addr   = 12'($urandom);
        in_rs1    = $urandom;
        in_uimm   = 5'($urandom);
        lat = 1; seen = 0; wen_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (csr_wen) begin
                wen_n++;
                wd = csr_wdata;
                wa = csr_addr;
                wen_lat = lat;
            end
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL out_valid_timeout: got none want valid for addr %h", v.addr);
            return;
        end
        check("latency", lat, v.lat);
        check("wen_count", wen_n, v.wen ? 1 : 0);
        if (v.wen) begin
            check("wdata", wd, v.wdata);
            check("wen_addr", {20'b0, wa}, {20'b0, v.addr});
            check("wen_cycle", wen_lat, v.lat - 1);
        end
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got output want queued entry");
        end else begin
            got = sbq.pop_front();
            check("rdata", out_rdata, got.rdata);
            check("illegal", {31'b0, out_illegal}, {31'b0, got.illegal});
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clock);
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_rdata", out_rdata, got.rdata);
                check("hold_illegal", {31'b0, out_illegal}, {31'b0, got.illegal});
                check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
        check("resp_addr", {20'b0, csr_addr}, {20'b0, v.addr});
        check("resp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("post_valid", {31'b0, out_valid}, 32'd0);
        check("post_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_addr", {20'b0, csr_addr}, 32'd0);
        check("post_wen", {31'b0, csr_wen}, 32'd0);
    endtask

    initial begin
        logic [31:0] pre;
        int          wen_n;
        int          vld_n;
        bit          hit;

        //          f3      addr     rs1           uimm   rdata         ill  wen  wdata     lat hold mcyc
        vec[0]  = '{3'b010, 12'hF11, 32'h0000FFFF, 5'd0,  32'h79737978, 1'b0, 1'b0, 32'h0,    2, 0, 1'b0};
        vec[1]  = '{3'b001, 12'hB00, 32'h00000100, 5'd3,  32'h0,        1'b0, 1'b1, 32'h100,  3, 0, 1'b1};
        vec[2]  = '{3'b111, 12'hB80, 32'hFFFFFFFF, 5'd3,  32'h7,        1'b0, 1'b1, 32'h4,    3, 0, 1'b0};
        vec[3]  = '{3'b001, 12'hF12, 32'h00000001, 5'd1,  32'h017E8A76, 1'b1, 1'b0, 32'h0,    2, 0, 1'b0};
        vec[4]  = '{3'b010, 12'h340, 32'h00000F00, 5'd5,  32'hF0,       1'b0, 1'b1, 32'hFF0,  3, 0, 1'b0};
        vec[5]  = '{3'b011, 12'h340, 32'h00000F0F, 5'd1,  32'hFF0,      1'b0, 1'b1, 32'h0F0,  3, 2, 1'b0};
        vec[6]  = '{3'b101, 12'h340, 32'h0,        5'h1F, 32'hF0,       1'b0, 1'b1, 32'h1F,   3, 0, 1'b0};
        vec[7]  = '{3'b110, 12'h340, 32'hFFFFFFFF, 5'd0,  32'h1F,       1'b0, 1'b0, 32'h0,    2, 0, 1'b0};
        vec[8]  = '{3'b011, 12'h340, 32'h0000FFFF, 5'd0,  32'h1F,       1'b0, 1'b0, 32'h0,    2, 0, 1'b0};
        vec[9]  = '{3'b000, 12'h340, 32'h12345678, 5'd4,  32'h0,        1'b1, 1'b0, 32'h0,    1, 0, 1'b0};
        vec[10] = '{3'b101, 12'h340, 32'hFFFFFFFF, 5'd0,  32'h1F,       1'b0, 1'b1, 32'h0,    3, 0, 1'b0};
        vec[11] = '{3'b100, 12'h123, 32'hFFFFFFFF, 5'd9,  32'h0,        1'b1, 1'b0, 32'h0,    1, 5, 1'b0};

        reset     = 1'b0;
        mdl_init  = 1'b1;
        in_valid  = 1'b0;
        in_funct3 = 3'b0;
        in_addr   = 12'h0;
        in_rs1    = 32'h0;
        in_uimm   = 5'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_wen", {31'b0, csr_wen}, 32'd0);
        check("rst_addr", {20'b0, csr_addr}, 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_rdata", out_rdata, 32'd0);
        check("rst_illegal", {31'b0, out_illegal}, 32'd0);

        reset    = 1'b1;
        mdl_init = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 12; i++) do_op(vec[i]);

        // reset dropped while a CSRRW sits in WRITE: the write must never land
        @(negedge clock);
        pre       = mscratch;
        in_valid  = 1'b1;
        in_funct3 = 3'b001;
        in_addr   = 12'h340;
        in_rs1    = 32'hDEADBEEF;
        in_uimm   = 5'd1;
        @(negedge clock);
        in_valid = 1'b0;
        hit = 0;
        for (int k = 0; k < 10; k++) begin
            if (csr_wen) begin
                hit = 1;
                break;
            end
            @(negedge clock);
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL wen_timeout: got no csr_wen want one before reset");
        end
        reset = 1'b0;
        #1;
        check("mid_rst_wen", {31'b0, csr_wen}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_addr", {20'b0, csr_addr}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wen_n = 0; vld_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (csr_wen) wen_n++;
            if (out_valid) vld_n++;
        end
        check("after_rst_wen", wen_n, 0);
        check("after_rst_valid", vld_n, 0);
        check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("after_rst_mscratch", mscratch, pre);

        // block recovers and runs a normal op
        do_op(vec[0]);
        check("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
